km_mm_pipe: RTL and testbench

//  Multi-lane, fully pipelined Montgomery modular multiplier with a valid/ready handshake.
//  It is the parametrised successor of km_mm and serves the NTT datapath: one lane per butterfly unit.

---
 rtl/km_mm_pipe_pkg.sv | 14 +
 rtl/km_mm_pipe_if.sv | 32 +++
 rtl/km_mm_pipe_lane.sv | 45 ++++
 rtl/km_mm_pipe.sv | 73 +++++++
 tb/tb_km_mm_pipe.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/km_mm_pipe_pkg.sv
// Shared definitions for the multi-lane Montgomery multiplier pipeline.
package km_mm_pipe_pkg;

    localparam int DW_DEF    = 30;
    localparam int LANES_DEF = 2;
    localparam int TW_DEF    = 4;
    localparam int LAT       = 4;

    typedef enum logic {
        MODE_MUL       = 1'b0,
        MODE_FROM_MONT = 1'b1
    } mode_e;

endpackage

// File: rtl/km_mm_pipe_if.sv
// Operand/result handshake bundle for km_mm_pipe, plus quasi-static p/mu and busy.
interface km_mm_pipe_if
    import km_mm_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int TW    = TW_DEF
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_mode;
    logic [TW-1:0]         in_tag;
    logic [LANES*DW-1:0]   in1;
    logic [LANES*DW-1:0]   in2;
    logic [DW-1:0]         p;
    logic [DW-1:0]         mu;
    logic                  out_valid;
    logic                  out_ready;
    logic [TW-1:0]         out_tag;
    logic [LANES*DW-1:0]   out;
    logic                  busy;

    modport master (
        output in_valid, in_mode, in_tag, in1, in2, p, mu, out_ready,
        input  in_ready, out_valid, out_tag, out, busy
    );

    modport slave (
        input  in_valid, in_mode, in_tag, in1, in2, p, mu, out_ready,
        output in_ready, out_valid, out_tag, out, busy
    );
endinterface

// File: rtl/km_mm_pipe_lane.sv
// One lane of the Montgomery multiplier: product, m = t*mu mod R, reduction.
module km_mm_pipe_lane
    import km_mm_pipe_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] p,
    input  logic [DW-1:0] mu,
    output logic [DW-1:0] out
);
    logic [2*DW-1:0] t2_q;
    logic [2*DW-1:0] t3_q;
    logic [DW-1:0]   m3_q;
    logic [2*DW:0]   sum_d;
    logic [DW:0]     u_d;
    logic [DW-1:0]   out_d;

    // Reduction: u = (t + m*p) / R is below 2p, so one conditional subtract lands in [0,p-1]
    always_comb begin
        sum_d = {1'b0, t3_q} + ({{(DW+1){1'b0}}, m3_q} * {{(DW+1){1'b0}}, p});
        u_d   = (DW+1)'(sum_d >> DW);
        out_d = (u_d >= {1'b0, p}) ? DW'(u_d - {1'b0, p}) : u_d[DW-1:0];
    end

    // S2..S4 registers, all frozen together on a global stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t2_q <= '0;
            t3_q <= '0;
            m3_q <= '0;
            out  <= '0;
        end else if (en) begin
            t2_q <= {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
            m3_q <= t2_q[DW-1:0] * mu;
            t3_q <= t2_q;
            out  <= out_d;
        end
    end

endmodule

// File: rtl/km_mm_pipe.sv
// Multi-lane pipelined Montgomery multiplier (a*b*R^-1 mod p) with valid/ready.
// Latency counts the accept cycle: a set presented in cycle n is on out in cycle n+LAT.
// The interface instance must be parameterised with the same DW/LANES/TW.
module km_mm_pipe
    import km_mm_pipe_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int TW    = TW_DEF
) (
    input logic         clk,
    input logic         rstn,
    km_mm_pipe_if.slave bus
);
    logic                stall;
    logic                en;
    logic                accept;
    mode_e               mode;
    logic [LAT-1:0]      vld_q;
    logic [TW-1:0]       tag_q [LAT];
    logic [LANES*DW-1:0] a_q;
    logic [LANES*DW-1:0] b_q;
    logic [LANES*DW-1:0] out_w;

    assign stall         = bus.out_valid & ~bus.out_ready;
    assign en            = ~stall;
    assign accept        = bus.in_valid & en;
    assign mode          = mode_e'(bus.in_mode);
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_q[LAT-1];
    assign bus.out_tag   = tag_q[LAT-1];
    assign bus.out       = out_w;
    assign bus.busy      = |vld_q;

    // Valid/tag shift chain; bubbles move with data, everything holds on stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (en) begin
            vld_q    <= {vld_q[LAT-2:0], accept};
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // S1 operand capture; leaving the Montgomery domain is a multiply by 1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            a_q <= bus.in1;
            for (int i = 0; i < LANES; i++) begin
                b_q[i*DW +: DW] <= (mode == MODE_FROM_MONT) ? DW'(1) : bus.in2[i*DW +: DW];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        km_mm_pipe_lane #(.DW(DW)) u_lane (
            .clk  (clk),
            .rstn (rstn),
            .en   (en),
            .a    (a_q[g*DW +: DW]),
            .b    (b_q[g*DW +: DW]),
            .p    (bus.p),
            .mu   (bus.mu),
            .out  (out_w[g*DW +: DW])
        );
    end

endmodule

// File: tb/tb_km_mm_pipe.sv
// Directed and streamed checks of km_mm_pipe (DW=30, LANES=2, TW=4).
module tb_km_mm_pipe;

    localparam longint unsigned P      = 64'd343576577;
    localparam longint unsigned RINV   = 64'd18675318;
    localparam logic [29:0]     RMODP  = 30'd43012093;
    localparam logic [29:0]     PM1    = 30'd343576576;
    localparam int              LAT_EXP = 4;

    typedef struct {
        logic        mode;
        logic [3:0]  tag;
        logic [29:0] a0, b0, a1, b1;
        logic [29:0] e0, e1;
        int          acc_cyc;
    } set_t;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    int   cyc;
    set_t stim_q[$];
    set_t exp_q[$];
    logic        hold_pend;
    logic [59:0] held_out;
    logic [3:0]  held_tag;

    km_mm_pipe_if #(.DW(30), .LANES(2), .TW(4)) bus ();

    km_mm_pipe #(.DW(30), .LANES(2), .TW(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    function automatic logic [29:0] calc_mu();
        longint unsigned x;
        x = P;
        for (int i = 0; i < 6; i++) x = x * (64'd2 - P * x);
        return 30'(64'd0 - x);
    endfunction

    function automatic logic [29:0] model(input logic mode, input logic [29:0] a, input logic [29:0] b);
        longint unsigned aa, bb, x;
        aa = {34'd0, a};
        bb = {34'd0, b};
        x  = mode ? (aa % P) : ((aa * bb) % P);
        return 30'((x * RINV) % P);
    endfunction

    function automatic set_t mk_set(input logic mode, input logic [3:0] tag,
                                    input logic [29:0] a0, input logic [29:0] b0,
                                    input logic [29:0] a1, input logic [29:0] b1,
                                    input logic [29:0] e0, input logic [29:0] e1);
        set_t s;
        s.mode = mode; s.tag = tag;
        s.a0 = a0; s.b0 = b0; s.a1 = a1; s.b1 = b1;
        s.e0 = e0; s.e1 = e1; s.acc_cyc = 0;
        return s;
    endfunction

    function automatic set_t rnd_set();
        logic [29:0] a0, b0, a1, b1;
        logic        m;
        logic [3:0]  t;
        a0 = 30'($urandom_range(0, 343576576));
        b0 = 30'($urandom_range(0, 343576576));
        a1 = 30'($urandom_range(0, 343576576));
        b1 = 30'($urandom_range(0, 343576576));
        m  = 1'($urandom_range(0, 1));
        t  = 4'($urandom_range(0, 15));
        return mk_set(m, t, a0, b0, a1, b1, model(m, a0, b0), model(m, a1, b1));
    endfunction

    task automatic drive_set(input set_t s);
        bus.in_mode = s.mode;
        bus.in_tag  = s.tag;
        bus.in1     = {s.a1, s.a0};
        bus.in2     = {s.b1, s.b0};
    endtask

    // One cycle: drive at the falling edge, observe 1 ns later, book-keep the transfers of the next rise
    task automatic step(input bit rnd_ready, input bit chk_lat);
        set_t e;
        @(negedge clk);
        cyc++;
        bus.out_ready = rnd_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
        if (stim_q.size() != 0) begin
            bus.in_valid = 1'b1;
            drive_set(stim_q[0]);
        end else begin
            bus.in_valid = 1'b0;
        end
        #1;
        if (hold_pend) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_out", 64'(bus.out), 64'(held_out));
            chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_lane0", 64'(bus.out[29:0]), 64'(e.e0));
                chk("out_lane1", 64'(bus.out[59:30]), 64'(e.e1));
                chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                if (chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'(LAT_EXP));
            end
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        held_out  = bus.out;
        held_tag  = bus.out_tag;
        if (bus.in_valid && bus.in_ready) begin
            e = stim_q.pop_front();
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_sets(input int budget, input bit rnd_ready, input bit chk_lat);
        int left;
        left = budget;
        hold_pend = 1'b0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && left > 0) begin
            step(rnd_ready, chk_lat);
            left--;
        end
        chk("drain_left", 64'(stim_q.size() + exp_q.size()), 64'd0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        hold_pend = 1'b0;
        held_out  = '0;
        held_tag  = '0;
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_tag    = '0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.out_ready = 1'b1;
        bus.p         = 30'(P);
        bus.mu        = calc_mu();

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed back-to-back sets, consumer always ready
        stim_q.push_back(mk_set(1'b0, 4'hA, PM1, PM1, PM1, PM1, 30'd18675318, 30'd18675318));
        stim_q.push_back(mk_set(1'b0, 4'h3, RMODP, 30'd123456, 30'd0, 30'd0, 30'd123456, 30'd0));
        stim_q.push_back(mk_set(1'b1, 4'h9, 30'd1, 30'd7777, RMODP, 30'd7777, 30'd18675318, 30'd1));
        stim_q.push_back(mk_set(1'b0, 4'h5, PM1, PM1, 30'd0, 30'd0, 30'd18675318, 30'd0));
        run_sets(100, 1'b0, 1'b1);

        // Random stream with a pseudo-random consumer
        for (int k = 0; k < 1000; k++) stim_q.push_back(rnd_set());
        run_sets(8000, 1'b1, 1'b0);

        // Reset with three sets in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            drive_set(rnd_set());
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("inflight_busy", 64'(bus.busy), 64'd1);
        chk("inflight_out_valid", 64'(bus.out_valid), 64'd0);
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        stim_q.push_back(mk_set(1'b0, 4'hC, RMODP, 30'd123456, PM1, PM1, 30'd123456, 30'd18675318));
        run_sets(100, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
